// File: rtl/xbar_out_port_pkg.sv
// rtl/xbar_out_port_pkg.sv - flit type, port index and lock state encodings for xbar_out_port
package xbar_out_port_pkg;

  localparam int FLIT_TYPE_W = 3;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    FLIT_HEADER = 3'b001,
    FLIT_BODY   = 3'b010,
    FLIT_TAIL   = 3'b100
  } flit_type_e;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_E = 3'd1,
    PORT_W = 3'd2,
    PORT_S = 3'd3,
    PORT_L = 3'd4
  } port_idx_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/xbar_pipe_reg.sv
// rtl/xbar_pipe_reg.sv - one-deep valid/ready output register toward the link
module xbar_pipe_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  readyin,
  output logic [DATA_WIDTH-1:0] dataout,
  output logic                  validout
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;

  // Data only moves on load, so it is frozen while the link stalls.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = din;
      valid_d = 1'b1;
    end else if (readyin) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign dataout  = data_q;
  assign validout = valid_q;

endmodule

// File: rtl/xbar_out_port.sv
// rtl/xbar_out_port.sv - crossbar output port: input mux, packet lock FSM, FIFO pop strobes
module xbar_out_port
  import xbar_out_port_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 5,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SEL_WIDTH-1:0]         sel_in,
  input  logic                         sel_valid,
  input  logic [NUM_IN*DATA_WIDTH-1:0] datain,
  input  logic [NUM_IN-1:0]            validin,
  output logic [NUM_IN-1:0]            readout,
  output logic [DATA_WIDTH-1:0]        dataout,
  output logic                         validout,
  input  logic                         readyin,
  output logic                         locked,
  output logic [SEL_WIDTH-1:0]         lock_port,
  output logic                         sel_err
);

  lock_state_e           state_q, state_d;
  logic [SEL_WIDTH-1:0]  lock_port_q, lock_port_d;
  logic                  sel_err_q, sel_err_d;

  logic [DATA_WIDTH-1:0] sel_flit, lock_flit, load_flit;
  logic [NUM_IN-1:0]     sel_onehot, lock_onehot, pop;
  logic                  sel_in_range, sel_ne, lock_ne;
  logic [FLIT_TYPE_W-1:0] sel_type, lock_type;
  logic                  out_free, accept;

  // Out-of-range grant indices match no port and leave sel_in_range low.
  always_comb begin
    sel_flit     = '0;
    lock_flit    = '0;
    sel_onehot   = '0;
    lock_onehot  = '0;
    sel_in_range = 1'b0;
    sel_ne       = 1'b0;
    lock_ne      = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel_in == SEL_WIDTH'(i)) begin
        sel_flit      = datain[i*DATA_WIDTH +: DATA_WIDTH];
        sel_onehot[i] = 1'b1;
        sel_in_range  = 1'b1;
        sel_ne        = validin[i];
      end
      if (lock_port_q == SEL_WIDTH'(i)) begin
        lock_flit      = datain[i*DATA_WIDTH +: DATA_WIDTH];
        lock_onehot[i] = 1'b1;
        lock_ne        = validin[i];
      end
    end
  end

  assign sel_type  = sel_flit[DATA_WIDTH-1 -: FLIT_TYPE_W];
  assign lock_type = lock_flit[DATA_WIDTH-1 -: FLIT_TYPE_W];
  assign out_free  = !validout || readyin;

  always_comb begin
    state_d     = state_q;
    lock_port_d = lock_port_q;
    sel_err_d   = 1'b0;
    pop         = '0;
    load_flit   = sel_flit;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          if (!sel_in_range || (sel_ne && sel_type != FLIT_HEADER)) begin
            sel_err_d = 1'b1;
          end else if (sel_ne && out_free) begin
            pop         = sel_onehot;
            lock_port_d = sel_in;
            state_d     = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        load_flit = lock_flit;
        if (lock_ne && out_free) begin
          pop = lock_onehot;
          if (lock_type == FLIT_TAIL)   state_d   = ST_IDLE;
          if (lock_type == FLIT_HEADER) sel_err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      lock_port_q <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_port_q <= lock_port_d;
      sel_err_q   <= sel_err_d;
    end
  end

  // Pops are suppressed during reset so the FIFOs are never drained by a held-off port.
  assign accept    = rst && (pop != '0);
  assign readout   = rst ? pop : '0;
  assign locked    = (state_q == ST_LOCKED);
  assign lock_port = lock_port_q;
  assign sel_err   = sel_err_q;

  xbar_pipe_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .din     (load_flit),
    .readyin (readyin),
    .dataout (dataout),
    .validout(validout)
  );

endmodule
